// File: rtl/lfsr_pkg.sv
// Shared types, default tap masks and the single-step LFSR function for the
// lfsr_prng_stream block.
package lfsr_pkg;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } lfsr_fsm_e;

    // Maximal-length Fibonacci tap masks for the common widths.
    localparam logic [7:0]  LFSR_TAPS_W8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_W16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_W32 = 32'h80200003;

    localparam int unsigned LFSR_MAX_WIDTH = 64;

    // One Fibonacci step on the low `width` bits; `mix` is folded into the
    // feedback bit so entropy injection can reuse the same step.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_step(
        input logic [LFSR_MAX_WIDTH-1:0] state,
        input logic [LFSR_MAX_WIDTH-1:0] taps,
        input int unsigned               width,
        input logic                      mix = 1'b0
    );
        logic [LFSR_MAX_WIDTH-1:0] mask;
        logic                      fb;
        mask = (64'd1 << width) - 64'd1;
        fb   = (^(state & taps & mask)) ^ mix;
        return ((state << 1) | {{(LFSR_MAX_WIDTH-1){1'b0}}, fb}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational multi-step advance: OUT_BITS chained LFSR steps in one cycle.
// With LFSR_MIX_EN defined, ^mix_in is XORed into every step's feedback.
module lfsr_advance
    import lfsr_pkg::*;
#(
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
    parameter int              OUT_BITS = 4
) (
    input  logic [WIDTH-1:0] state_i,
`ifdef LFSR_MIX_EN
    input  logic [WIDTH-1:0] mix_in,
`endif
    output logic [WIDTH-1:0] next_o,
    output logic             zero_o
);

    logic             mix_bit;
    logic [WIDTH-1:0] chain [OUT_BITS+1];

`ifdef LFSR_MIX_EN
    assign mix_bit = ^mix_in;
`else
    assign mix_bit = 1'b0;
`endif

    assign chain[0] = state_i;

    for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_step
        assign chain[gi+1] = WIDTH'(lfsr_step(LFSR_MAX_WIDTH'(chain[gi]),
                                              LFSR_MAX_WIDTH'(TAPS),
                                              WIDTH, mix_bit));
    end

    assign next_o = chain[OUT_BITS];
    // Only the end of the advance is architecturally visible, so that is
    // where the all-zero lockup is judged.
    assign zero_o = ~|chain[OUT_BITS];

endmodule

// File: rtl/lfsr_prng_stream.sv
// Fibonacci LFSR PRNG with seed handshake, warm-up phase and valid/ready
// output stream. Optional entropy input mix_in is enabled by LFSR_MIX_EN.
module lfsr_prng_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter int               OUT_BITS = 4,
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(1),
    parameter int               WARMUP   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_valid,
    output logic                seed_ready,
    input  logic [WIDTH-1:0]    seed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                busy,
    output logic                lockup_err
`ifdef LFSR_MIX_EN
    ,
    input  logic [WIDTH-1:0]    mix_in
`endif
);

    localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CW-1:0] WARM_LAST = (WARMUP > 0) ? CW'(WARMUP - 1) : '0;

    lfsr_fsm_e        fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] adv_next;
    logic             adv_zero;
    logic             seed_hs;
    logic             out_hs;

    lfsr_advance #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .OUT_BITS (OUT_BITS)
    ) u_advance (
        .state_i (state_q),
`ifdef LFSR_MIX_EN
        .mix_in  (mix_in),
`endif
        .next_o  (adv_next),
        .zero_o  (adv_zero)
    );

    assign seed_hs = (fsm_q == RUN) && seed_valid;
    assign out_hs  = (fsm_q == RUN) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= WARM;
            state_q  <= INIT;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        lockup_d = lockup_q;
        case (fsm_q)
            WARM: begin
                if (WARMUP == 0) begin
                    fsm_d = RUN;
                end else begin
                    state_d = adv_zero ? INIT : adv_next;
                    if (adv_zero) begin
                        lockup_d = 1'b1;
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == WARM_LAST) begin
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
                // A seed wins over a simultaneous output beat: the beat is
                // still consumed but its advance is dropped.
                if (seed_hs) begin
                    cnt_d = '0;
                    // With no warm-up the seeded value is valid on the very
                    // next cycle, so WARM is skipped.
                    fsm_d = (WARMUP == 0) ? RUN : WARM;
                    if (seed == '0) begin
                        state_d  = INIT;
                        lockup_d = 1'b1;
                    end else begin
                        state_d = seed;
                    end
                end else if (out_hs) begin
                    state_d = adv_zero ? INIT : adv_next;
                    if (adv_zero) begin
                        lockup_d = 1'b1;
                    end
                end
            end
            default: begin
                fsm_d = WARM;
            end
        endcase
    end

    always_comb begin
        out_valid  = (fsm_q == RUN);
        seed_ready = (fsm_q == RUN);
        busy       = (fsm_q == WARM);
        out_data   = state_q[OUT_BITS-1:0];
        lockup_err = lockup_q;
    end

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Directed bench for lfsr_prng_stream: 8-bit LFSR (taps 0xB8, 1 bit/beat),
// one instance without warm-up and one with WARMUP=4.
module tb_lfsr_prng_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       sv0 = 1'b0, sr0, ov0, ord0 = 1'b1, busy0, le0;
    logic [7:0] seed0 = 8'h00;
    logic [0:0] od0;
    logic       sv4 = 1'b0, sr4, ov4, ord4 = 1'b0, busy4, le4;
    logic [7:0] seed4 = 8'h00;
    logic [0:0] od4;
`ifdef LFSR_MIX_EN
    logic [7:0] mix0 = 8'h00;
    logic [7:0] mix4 = 8'h00;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] m0;

    always #5 clk = ~clk;

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .OUT_BITS(1), .INIT(8'h01), .WARMUP(0)) dut0 (
        .clk(clk), .rst(rst), .seed_valid(sv0), .seed_ready(sr0), .seed(seed0),
        .out_valid(ov0), .out_ready(ord0), .out_data(od0), .busy(busy0), .lockup_err(le0)
`ifdef LFSR_MIX_EN
        , .mix_in(mix0)
`endif
    );

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .OUT_BITS(1), .INIT(8'h01), .WARMUP(4)) dut4 (
        .clk(clk), .rst(rst), .seed_valid(sv4), .seed_ready(sr4), .seed(seed4),
        .out_valid(ov4), .out_ready(ord4), .out_data(od4), .busy(busy4), .lockup_err(le4)
`ifdef LFSR_MIX_EN
        , .mix_in(mix4)
`endif
    );

    function automatic logic [7:0] m_step(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", ov0); end
        checks++; if (sr0 !== 1'b0) begin failures++; $display("FAIL reset_seed_ready got=%b want=0", sr0); end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", busy0); end
        checks++; if (le0 !== 1'b0) begin failures++; $display("FAIL reset_lockup got=%b want=0", le0); end
        checks++; if (dut0.state_q !== 8'h01) begin failures++; $display("FAIL reset_state got=%h want=01", dut0.state_q); end
        checks++; if (busy4 !== 1'b1 || ov4 !== 1'b0) begin failures++; $display("FAIL reset_dut4 busy=%b valid=%b want busy=1 valid=0", busy4, ov4); end
        $display("reset: state=%h busy=%b valid=%b", dut0.state_q, busy0, ov0);
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        logic [7:0] hand [5];
        logic [7:0] exp_s;
        int errs;
        int reps;
        hand[0] = 8'h01; hand[1] = 8'h02; hand[2] = 8'h04; hand[3] = 8'h08; hand[4] = 8'h11;
        exp_s = 8'h01;
        errs = 0;
        reps = 0;
        @(negedge clk);
        checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL seq_valid_after_reset got=%b want=1", ov0); end
        for (int i = 0; i < 255; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 5) begin
                checks++;
                if (dut0.state_q !== hand[i] || od0 !== hand[i][0]) begin
                    failures++;
                    $display("FAIL seq_beat%0d got state=%h data=%b want state=%h data=%b", i, dut0.state_q, od0, hand[i], hand[i][0]);
                end
                $display("seq beat %0d: state=%h data=%b", i, dut0.state_q, od0);
            end else if (dut0.state_q !== exp_s) begin
                errs++;
            end
            if (i > 0 && dut0.state_q === 8'h01) reps++;
            exp_s = m_step(exp_s);
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL seq_model got_mismatches=%0d want=0", errs); end
        checks++; if (reps !== 0) begin failures++; $display("FAIL seq_early_repeat got=%0d want=0", reps); end
        @(negedge clk);
        checks++; if (dut0.state_q !== 8'h01) begin failures++; $display("FAIL seq_period255 got=%h want=01", dut0.state_q); end
        $display("seq after 255 beats: state=%h", dut0.state_q);
        m0 = 8'h01;
    endtask

    task automatic test_stall();
        int errs;
        errs = 0;
        ord0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dut0.state_q !== m0 || od0 !== m0[0] || ov0 !== 1'b1) errs++;
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL stall_hold got_mismatches=%0d want=0", errs); end
        $display("stall: state=%h held 10 cycles", dut0.state_q);
        ord0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m0 = m_step(m0);
            checks++;
            if (dut0.state_q !== m0) begin failures++; $display("FAIL stall_resume%0d got=%h want=%h", i, dut0.state_q, m0); end
            $display("resume %0d: state=%h", i, dut0.state_q);
        end
        ord0 = 1'b0;
    endtask

    task automatic test_zero_seed();
        checks++; if (sr0 !== 1'b1) begin failures++; $display("FAIL zseed_ready got=%b want=1", sr0); end
        seed0 = 8'h00; sv0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        checks++; if (dut0.state_q !== 8'h01) begin failures++; $display("FAIL zseed_state got=%h want=01", dut0.state_q); end
        checks++; if (le0 !== 1'b1) begin failures++; $display("FAIL zseed_lockup got=%b want=1", le0); end
        $display("zero seed: state=%h lockup=%b", dut0.state_q, le0);
        seed0 = 8'h33; sv0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        checks++; if (dut0.state_q !== 8'h33 || ov0 !== 1'b1) begin failures++; $display("FAIL reseed_state got=%h valid=%b want=33 valid=1", dut0.state_q, ov0); end
        checks++; if (le0 !== 1'b1) begin failures++; $display("FAIL lockup_sticky got=%b want=1", le0); end
        $display("reseed 33: state=%h lockup=%b", dut0.state_q, le0);
    endtask

    task automatic test_seed_latency();
        checks++; if (ov4 !== 1'b1 || dut4.state_q !== 8'h11) begin failures++; $display("FAIL warm_after_reset got state=%h valid=%b want=11 valid=1", dut4.state_q, ov4); end
        seed4 = 8'h08; sv4 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            sv4 = 1'b0;
            checks++;
            if (busy4 !== 1'b1 || ov4 !== 1'b0) begin failures++; $display("FAIL latency_warm_t%0d busy=%b valid=%b want busy=1 valid=0", k, busy4, ov4); end
        end
        @(negedge clk);
        checks++; if (ov4 !== 1'b1 || busy4 !== 1'b0) begin failures++; $display("FAIL latency_t5 valid=%b busy=%b want valid=1 busy=0", ov4, busy4); end
        checks++; if (dut4.state_q !== 8'h8E) begin failures++; $display("FAIL latency_state got=%h want=8e", dut4.state_q); end
        $display("seed 08: state at t+5=%h valid=%b", dut4.state_q, ov4);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_s;
        checks++; if (ov4 !== 1'b1 || od4 !== 1'b0) begin failures++; $display("FAIL b2b_beat valid=%b data=%b want valid=1 data=0", ov4, od4); end
        ord4 = 1'b1; sv4 = 1'b1; seed4 = 8'h5A;
        @(negedge clk);
        ord4 = 1'b0; sv4 = 1'b0;
        checks++; if (dut4.state_q !== 8'h5A) begin failures++; $display("FAIL b2b_state got=%h want=5a", dut4.state_q); end
        checks++; if (busy4 !== 1'b1 || ov4 !== 1'b0) begin failures++; $display("FAIL b2b_warm busy=%b valid=%b want busy=1 valid=0", busy4, ov4); end
        $display("seed 5a with beat: state=%h busy=%b", dut4.state_q, busy4);
        exp_s = m_step(m_step(m_step(m_step(8'h5A))));
        repeat (4) @(negedge clk);
        checks++; if (ov4 !== 1'b1 || dut4.state_q !== exp_s) begin failures++; $display("FAIL b2b_after_warm state=%h valid=%b want=%h valid=1", dut4.state_q, ov4, exp_s); end
    endtask

    task automatic test_async_reset();
        seed4 = 8'h00; sv4 = 1'b1;
        @(negedge clk);
        sv4 = 1'b0;
        checks++; if (le4 !== 1'b1 || busy4 !== 1'b1) begin failures++; $display("FAIL ar_pre lockup=%b busy=%b want 1 1", le4, busy4); end
        @(posedge clk);
        #2;
        checks++; if (dut4.state_q !== 8'h02) begin failures++; $display("FAIL ar_warm_step got=%h want=02", dut4.state_q); end
        rst = 1'b1;
        #1;
        checks++; if (dut4.state_q !== 8'h01 || busy4 !== 1'b1 || ov4 !== 1'b0 || sr4 !== 1'b0) begin
            failures++; $display("FAIL ar_dut4 state=%h busy=%b valid=%b ready=%b want 01 1 0 0", dut4.state_q, busy4, ov4, sr4);
        end
        checks++; if (le4 !== 1'b0 || le0 !== 1'b0) begin failures++; $display("FAIL ar_lockup_clear le4=%b le0=%b want 0 0", le4, le0); end
        $display("async reset: state=%h busy=%b lockup=%b", dut4.state_q, busy4, le4);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_zero_seed();
        test_seed_latency();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
